// File: rtl/off_chip_arbiter_pkg.sv
// Shared types and helpers for the off-chip channel arbiter.
package off_chip_pkg;

   localparam int DATA_W_DEF = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Index width for a requester id; never narrower than one bit.
   function automatic int REQ_IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/off_chip_arbiter_if.sv
// Requester-side and channel-side handshake bundle of the off-chip arbiter.
interface off_chip_arbiter_if
   import off_chip_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF
) ();

   localparam int IW = REQ_IDX_W(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;
   logic [IW-1:0]             grant_id;
   logic                      busy;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, grant_id, busy
   );

endinterface

// File: rtl/off_chip_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
   import off_chip_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = REQ_IDX_W(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               found_o,
   output logic [IW-1:0]      idx_o
);

   logic          hit;
   logic [IW-1:0] pick;
   logic [IW-1:0] cand;
   int            j;

   always_comb begin
      hit  = 1'b0;
      pick = '0;
      cand = '0;
      j    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IW'(j);
         if (!hit && req_i[cand]) begin
            hit  = 1'b1;
            pick = cand;
         end
      end
   end

   assign found_o = hit;
   assign idx_o   = pick;

endmodule

// File: rtl/off_chip_arbiter.sv
// Round-robin, burst-bounded arbiter feeding one registered valid/ready channel.
module off_chip_arbiter
   import off_chip_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   off_chip_arbiter_if.slave bus
);

   localparam int IW = REQ_IDX_W(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_e              state_q;
   logic [IW-1:0]       rr_ptr_q;
   logic [IW-1:0]       grant_id_q;
   logic [CW-1:0]       beat_cnt_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;

   logic [NUM_REQ-1:0][DATA_W-1:0] req_data_2d;
   logic                load_en;
   logic                grantee_vld;
   logic [DATA_W-1:0]   grantee_data;
   logic                accept;
   logic                release_c;
   logic [CW-1:0]       cnt_inc;
   logic [IW-1:0]       next_ptr;
   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [NUM_REQ-1:0]  ready_c;

   assign req_data_2d  = bus.req_data;
   assign grantee_vld  = bus.req_valid[grant_id_q];
   assign grantee_data = req_data_2d[grant_id_q];

   // Output slot is free when empty or draining this cycle.
   assign load_en = !out_valid_q || bus.out_ready;
   assign accept  = (state_q == GRANT) && load_en && grantee_vld;
   assign cnt_inc = beat_cnt_q + CW'(1);

   // A dropped valid ends the grant even mid-stall; a full burst ends it on its last beat.
   assign release_c = (state_q == GRANT) &&
                      (!grantee_vld || (accept && (cnt_inc == CW'(MAX_BURST))));
   assign next_ptr  = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);

   always_comb begin
      ready_c = '0;
      if ((state_q == GRANT) && load_en) ready_c[grant_id_q] = 1'b1;
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grantee_data;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         unique case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_id_q <= pick_idx;
                  beat_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (release_c) begin
                  rr_ptr_q <= next_ptr;
                  state_q  <= IDLE;
               end else if (accept) begin
                  beat_cnt_q <= cnt_inc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_off_chip_arbiter.sv
// Directed bench for off_chip_arbiter with a per-cycle behavioural reference.
module tb_off_chip_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   off_chip_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   off_chip_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Requester sources: beats pushed by the test, consumed as the reference accepts them.
   logic [63:0] src [N][64];
   int          tl    [N];
   int          m_pop [N];
   logic [N-1:0] en;
   bit          chk_en = 1'b0;

   // Reference state: who holds the channel, how many beats it took, where the search starts.
   bit          m_busy;
   int          m_grant, m_cnt, m_ptr;
   bit          m_ov;
   logic [63:0] m_od;

   logic [63:0] dut_out[$], glog[$], eo[$], eg[$];
   bit          vtr[$], btr[$];
   bit          prev_busy = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_seq(input string nm, input logic [63:0] got[$], input logic [63:0] exp[$]);
      chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
   endtask

   function automatic int gaps(input bit q[$]);
      int f = -1, l = -1, z = 0;
      for (int i = 0; i < q.size(); i++)
         if (q[i]) begin
            if (f < 0) f = i;
            l = i;
         end
      if (f >= 0)
         for (int i = f; i <= l; i++) if (!q[i]) z++;
      return z;
   endfunction

   task automatic push(input int r, input logic [63:0] v);
      src[r][tl[r]] = v;
      tl[r]++;
   endtask

   task automatic eo_add(input logic [63:0] base, input int n);
      for (int i = 0; i < n; i++) eo.push_back(base + 64'(i));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = en[i] && (m_pop[i] < tl[i]);
         bus.req_data[i*DW +: DW] = bus.req_valid[i] ? src[i][m_pop[i]] : '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      drive();
   endtask

   task automatic clear_logs();
      dut_out.delete(); glog.delete(); vtr.delete(); btr.delete();
      eo.delete(); eg.delete();
   endtask

   task automatic drain();
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 300) begin
         tick();
         n++;
         done = !m_busy && !m_ov;
         for (int i = 0; i < N; i++) if (m_pop[i] < tl[i]) done = 1'b0;
      end
      if (!done) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   // Reference: the owner of the channel moves one beat into the output slot whenever
   // the slot is free; a grant ends on a full burst or when the owner goes quiet.
   always @(posedge clk or negedge rst) begin
      bit ld, acc, v, f;
      int g, c;
      if (!rst) begin
         m_busy = 0; m_grant = 0; m_cnt = 0; m_ptr = 0; m_ov = 0; m_od = '0;
      end else begin
         g   = m_grant;
         v   = bus.req_valid[g];
         ld  = !m_ov || bus.out_ready;
         acc = m_busy && ld && v;
         if (acc) begin
            m_od = src[g][m_pop[g]];
            m_pop[g]++;
            m_ov = 1'b1;
         end else if (bus.out_ready) begin
            m_ov = 1'b0;
         end
         if (!m_busy) begin
            f = 1'b0;
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (!f && bus.req_valid[c]) begin
                  f = 1'b1;
                  m_grant = c;
               end
            end
            if (f) begin
               m_cnt  = 0;
               m_busy = 1'b1;
            end
         end else if (!v || (acc && (m_cnt + 1 == MB))) begin
            m_ptr  = (g + 1) % N;
            m_busy = 1'b0;
         end else if (acc) begin
            m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      if (chk_en) begin
         exp_rdy = (m_busy && (!m_ov || bus.out_ready)) ? (N'(1) << m_grant) : '0;
         chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
         chk("out_data",  bus.out_data, m_od);
         chk("busy",      64'(bus.busy), 64'(m_busy));
         chk("grant_id",  64'(bus.grant_id), 64'(m_grant));
         chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
         if (bus.out_valid && bus.out_ready) dut_out.push_back(bus.out_data);
         if (bus.busy && !prev_busy) glog.push_back(64'(bus.grant_id));
         vtr.push_back(bus.out_valid);
         btr.push_back(bus.busy);
      end
      prev_busy = bus.busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) tl[i] = 0;
      en = '0;
      bus.out_ready = 1'b1;
      drive();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  bus.out_data, 64'd0);
      chk("rst_busy",      64'(bus.busy), 64'd0);
      chk("rst_grant",     64'(bus.grant_id), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      // Reset mid-burst, then all four requesters: order 0,1,2,3,0.
      push(0, 64'hA0);
      en = 4'b0001;
      drive();
      tick();
      chk("t1_busy", 64'(bus.busy), 64'd1);
      tick();
      chk("t1_lat_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_lat_data",  bus.out_data, 64'hA0);
      chk_en = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("t1_async_valid", 64'(bus.out_valid), 64'd0);
      chk("t1_async_busy",  64'(bus.busy), 64'd0);
      chk("t1_async_grant", 64'(bus.grant_id), 64'd0);
      chk("t1_async_rdy",   64'(bus.req_ready), 64'd0);
      en = '0;
      drive();
      @(posedge clk);
      #2;
      for (int k = 0; k < 8; k++) push(0, 64'h100 + 64'(k));
      for (int r = 1; r < N; r++)
         for (int k = 0; k < 4; k++) push(r, 64'h100 * 64'(r + 1) + 64'(k));
      en = 4'b1111;
      rst = 1'b1;
      drive();
      clear_logs();
      chk_en = 1'b1;
      tick();
      chk("t3_first_grant", 64'(bus.grant_id), 64'd0);
      chk("t3_first_busy",  64'(bus.busy), 64'd1);
      drain();
      eo_add(64'h100, 4); eo_add(64'h200, 4); eo_add(64'h300, 4); eo_add(64'h400, 4);
      eo_add(64'h104, 4);
      eg.push_back(0); eg.push_back(1); eg.push_back(2); eg.push_back(3); eg.push_back(0);
      chk_seq("t3_data", dut_out, eo);
      chk_seq("t3_grants", glog, eg);
      chk("t3_bubbles", 64'(gaps(vtr)), 64'd4);

      // Single requester: 4 beats, one bubble, 2 beats.
      clear_logs();
      for (int k = 0; k < 6; k++) push(0, 64'h11 + 64'(k));
      en = 4'b0001;
      drive();
      tick();
      chk("t2_busy", 64'(bus.busy), 64'd1);
      chk("t2_nolat_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("t2_lat_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_lat_data",  bus.out_data, 64'h11);
      drain();
      eo_add(64'h11, 6);
      eg.push_back(0); eg.push_back(0);
      chk_seq("t2_data", dut_out, eo);
      chk_seq("t2_grants", glog, eg);
      chk("t2_bubbles", 64'(gaps(vtr)), 64'd1);

      // Back-pressure for 5 cycles mid-burst on requester 1.
      clear_logs();
      for (int k = 0; k < 4; k++) push(1, 64'h41 + 64'(k));
      en = 4'b0010;
      drive();
      repeat (3) tick();
      bus.out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("t4_hold_data",  bus.out_data, 64'h42);
         chk("t4_hold_rdy",   64'(bus.req_ready), 64'd0);
         chk("t4_hold_busy",  64'(bus.busy), 64'd1);
      end
      bus.out_ready = 1'b1;
      drain();
      eo_add(64'h41, 4);
      eg.push_back(1);
      chk_seq("t4_data", dut_out, eo);
      chk_seq("t4_grants", glog, eg);

      // Early release of grantee 2 while requester 3 waits.
      clear_logs();
      push(2, 64'h51); push(2, 64'h52);
      push(3, 64'h61); push(3, 64'h62);
      en = 4'b1100;
      drive();
      drain();
      eo_add(64'h51, 2); eo_add(64'h61, 2);
      eg.push_back(2); eg.push_back(3);
      chk_seq("t5_data", dut_out, eo);
      chk_seq("t5_grants", glog, eg);
      chk("t5_idle_cycles", 64'(gaps(btr)), 64'd1);

      // Wrap-around: park pointer at 3, then full burst from 3 hands over to 1.
      push(2, 64'h71);
      en = 4'b0100;
      drive();
      drain();
      clear_logs();
      for (int k = 0; k < 6; k++) push(3, 64'h81 + 64'(k));
      push(1, 64'h91); push(1, 64'h92);
      en = 4'b1010;
      drive();
      drain();
      eo_add(64'h81, 4); eo_add(64'h91, 2); eo_add(64'h85, 2);
      eg.push_back(3); eg.push_back(1); eg.push_back(3);
      chk_seq("t6_data", dut_out, eo);
      chk_seq("t6_grants", glog, eg);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/off_chip_arbiter.md
Name: off_chip_arbiter

Overview:
Shares the single 64-bit off-chip valid/ready datapath between NUM_REQ requesters using round-robin arbitration with bounded bursts.
Sits upstream of the off-chip channel and drives its valid_in/data_in/ready-side interface.
Provides a registered output stage so the off-chip channel sees glitch-free, held data.
Also serves as the shared front-end that feeds both the ILA and spec models in equivalence checking.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 64, beat width in bits
MAX_BURST, 4, max beats per grant before forced release (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_W  per-requester beat; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept
out_valid  output  1  beat valid toward the off-chip channel
out_data  output  DATA_W  beat toward the off-chip channel
out_ready  input  1  off-chip channel accept
grant_id  output  clog2(NUM_REQ)  current grantee, registered
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0.
  - out_valid=0; out_data=0; busy=0; req_ready=0.
  - Any in-flight beat is discarded.
- Output register:
  - load_en = !out_valid || out_ready.
  - An accepted beat loads out_data and sets out_valid=1.
  - If out_ready=1 and no beat is accepted, out_valid clears.
  - While out_valid=1 && out_ready=0, out_valid and out_data hold stable.
- Accept rules:
  - req_ready[i] = (state==GRANT) && (i==grant_id) && load_en. This is a combinational path from out_ready.
  - A beat is accepted when req_valid[grant_id] && req_ready[grant_id].
- State IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the pick into grant_id, clear beat_cnt, and go to GRANT.
  - No beat is accepted in IDLE.
- State GRANT (busy=1):
  - Each accepted beat increments beat_cnt. beat_cnt width is clog2(MAX_BURST+1).
  - Release when the accepted beat makes beat_cnt==MAX_BURST.
  - Also release when req_valid[grant_id]=0 in any GRANT cycle.
  - On release: rr_ptr <= (grant_id+1) mod NUM_REQ, then go to IDLE.
  - Back-pressure (out_ready=0 with out_valid=1) stalls in GRANT without release, as long as the grantee holds valid.
- Latency:
  - First beat of a grant: req_valid seen in IDLE (cycle 0), accepted in cycle 1, out_valid=1 in cycle 2.
  - Subsequent beats run back-to-back at one beat per cycle when out_ready=1.
- Simultaneous events:
  - Release always passes through IDLE, giving a one-cycle bubble between grants, even if another requester is already valid.
  - A requester deasserting valid in the same cycle as the MAX_BURST beat is a normal release.
- Data order: per requester, beat order is preserved; no beat is duplicated or dropped after acceptance.
- Wrap-around: grant_id=NUM_REQ-1 on release sets rr_ptr=0.

Decomposition:
- Package off_chip_pkg holds:
  - the DATA_W default (64);
  - the state enum {IDLE, GRANT};
  - the REQ_IDX_W = clog2(NUM_REQ) helper function.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, idx.
- All registers live in off_chip_arbiter.

Test Plan:
1. Reset mid-burst: assert rst=0 while out_valid=1 -> out_valid=0, busy=0, grant_id=0 immediately (asynchronous). After release, req0 is granted first.
2. Single requester: req_valid=4'b0001, data 0x11..0x16, out_ready=1 -> beats 0x11-0x14 emitted back-to-back, one IDLE bubble, then 0x15-0x16. rr_ptr=1 after the first release.
3. Round-robin: all four requesters valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0, with 4 beats each and 1 bubble between grants.
4. Back-pressure: out_ready=0 for 5 cycles mid-burst -> out_data holds the same value, req_ready=0, beat_cnt unchanged. Transfer resumes with no loss once out_ready=1.
5. Early release: grantee 2 drops valid after 2 beats while req3 is valid -> release, IDLE for one cycle, grant_id=3, rr_ptr=3.
6. Wrap-around: grantee 3 completes MAX_BURST while req1 and req3 are valid -> rr_ptr=0, next grant is 1.
